// File: rtl/aes_pkg.sv
`default_nettype none
// ============================================================================
// Module      : aes_pkg
// Description : Shared AES constants. Holds the S-box geometry, the state
//               encoding of the inverse S-box builder and the FIPS-197
//               forward S-box table for reference streams.
// Revision    : 1.0 - initial release
// ============================================================================
package aes_pkg;

   localparam int SBOX_WIDTH = 8;
   localparam int SBOX_DEPTH = 256;

   // Inverse-table builder states.
   typedef enum logic [1:0] {
      ST_LOAD  = 2'd0,
      ST_READY = 2'd1,
      ST_ERROR = 2'd2
   } sbox_state_t;

   // FIPS-197 forward S-box, entry i = S(i).
   localparam logic [7:0] FIPS_SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

endpackage : aes_pkg
`default_nettype wire

// File: rtl/inv_subbytes_if.sv
`default_nettype none
// ============================================================================
// Module      : inv_subbytes_if
// Description : Bus bundle for the inverse SubBytes stage: forward S-box
//               stream in, lookup request/response, table status.
// Revision    : 1.0 - initial release
// ============================================================================
interface inv_subbytes_if #(
   parameter int DATA_WIDTH = 128
) ();
   import aes_pkg::*;

   logic                  sbox_valid;
   logic [SBOX_WIDTH-1:0] sbox_out;
   logic                  tvalid;
   logic [DATA_WIDTH-1:0] in;
   logic                  tready;
   logic                  valid;
   logic [DATA_WIDTH-1:0] out;
   logic                  sbox_ready;
   logic                  sbox_err;

   modport master (
      output sbox_valid, sbox_out, tvalid, in,
      input  tready, valid, out, sbox_ready, sbox_err
   );

   modport slave (
      input  sbox_valid, sbox_out, tvalid, in,
      output tready, valid, out, sbox_ready, sbox_err
   );
endinterface : inv_subbytes_if
`default_nettype wire

// File: rtl/inv_sbox_builder.sv
`default_nettype none
// ============================================================================
// Module      : inv_sbox_builder
// Description : Builds the inverse S-box from the serial forward S-box
//               stream and verifies the stream is a permutation. A repeated
//               value locks the table into an error state until reset.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_sbox_builder
   import aes_pkg::*;
#(
   parameter int SBOX_WIDTH_P = SBOX_WIDTH,
   parameter int SBOX_DEPTH_P = SBOX_DEPTH
) (
   input  wire                     clk,
   input  wire                     reset_n,
   input  wire                     i_sbox_valid,
   input  wire  [SBOX_WIDTH_P-1:0] i_sbox_out,
   output logic [SBOX_WIDTH_P-1:0] o_inv_tab [SBOX_DEPTH_P],
   output logic                    o_sbox_ready,
   output logic                    o_sbox_err
);

   localparam int IDX_W = $clog2(SBOX_DEPTH_P);
   localparam logic [IDX_W-1:0] c_LAST_IDX = IDX_W'(SBOX_DEPTH_P - 1);

   sbox_state_t              r_state;
   sbox_state_t              w_state_nxt;
   logic [IDX_W-1:0]         r_index;
   logic [SBOX_DEPTH_P-1:0]  r_written;
   logic [SBOX_WIDTH_P-1:0]  r_inv_mem [SBOX_DEPTH_P];
   logic                     w_dup;
   logic                     w_wr_en;

   // A beat is a duplicate if its value has already been placed in the table.
   assign w_dup = r_written[i_sbox_out];

   // State register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= ST_LOAD;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic and table write enable; only LOAD accepts beats.
   always_comb begin
      w_state_nxt = r_state;
      w_wr_en     = 1'b0;
      case (r_state)
         ST_LOAD: begin
            if (i_sbox_valid) begin
               if (w_dup) begin
                  w_state_nxt = ST_ERROR;
               end else begin
                  w_wr_en = 1'b1;
                  if (r_index == c_LAST_IDX) begin
                     w_state_nxt = ST_READY;
                  end
               end
            end
         end
         ST_READY: w_state_nxt = ST_READY;
         ST_ERROR: w_state_nxt = ST_ERROR;
         default:  w_state_nxt = ST_ERROR;
      endcase
   end

   // Inverse table, written bitmap and beat index; index counts accepted beats only.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_index   <= '0;
         r_written <= '0;
         for (int k = 0; k < SBOX_DEPTH_P; k++) begin
            r_inv_mem[k] <= '0;
         end
      end else if (w_wr_en) begin
         r_index               <= r_index + 1'b1;
         r_written[i_sbox_out] <= 1'b1;
         r_inv_mem[i_sbox_out] <= SBOX_WIDTH_P'(r_index);
      end
   end

   assign o_inv_tab    = r_inv_mem;
   assign o_sbox_ready = (r_state == ST_READY);
   assign o_sbox_err   = (r_state == ST_ERROR);

endmodule : inv_sbox_builder
`default_nettype wire

// File: rtl/inv_subbytes.sv
`default_nettype none
// ============================================================================
// Module      : inv_subbytes
// Description : AES InvSubBytes stage. Applies the streamed-in inverse
//               S-box to every byte lane of the state with a single register
//               stage; lookups are accepted only once the table is verified.
// Revision    : 1.0 - initial release
// ============================================================================
module inv_subbytes
   import aes_pkg::*;
#(
   parameter int SBOX_WIDTH_P = SBOX_WIDTH,
   parameter int SBOX_DEPTH_P = SBOX_DEPTH,
   parameter int DATA_WIDTH   = 128
) (
   input  wire            clk,
   input  wire            reset_n,
   inv_subbytes_if.slave  bus_if
);

   localparam int NUM_LANES = DATA_WIDTH / SBOX_WIDTH_P;

   logic [SBOX_WIDTH_P-1:0] w_inv_tab [SBOX_DEPTH_P];
   logic                    w_sbox_ready;
   logic                    w_sbox_err;
   logic [DATA_WIDTH-1:0]   w_lookup;
   logic                    w_accept;
   logic                    r_valid;
   logic [DATA_WIDTH-1:0]   r_out;

   inv_sbox_builder #(
      .SBOX_WIDTH_P (SBOX_WIDTH_P),
      .SBOX_DEPTH_P (SBOX_DEPTH_P)
   ) u_builder (
      .clk          (clk),
      .reset_n      (reset_n),
      .i_sbox_valid (bus_if.sbox_valid),
      .i_sbox_out   (bus_if.sbox_out),
      .o_inv_tab    (w_inv_tab),
      .o_sbox_ready (w_sbox_ready),
      .o_sbox_err   (w_sbox_err)
   );

   // One table read per byte lane.
   generate
      for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
         assign w_lookup[l*SBOX_WIDTH_P +: SBOX_WIDTH_P] =
            w_inv_tab[bus_if.in[l*SBOX_WIDTH_P +: SBOX_WIDTH_P]];
      end
   endgenerate

   // Requests outside READY are dropped, never queued.
   assign w_accept = bus_if.tvalid && w_sbox_ready;

   // Result register: capture on accept, otherwise hold data and drop valid.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_valid <= 1'b0;
         r_out   <= '0;
      end else begin
         r_valid <= w_accept;
         if (w_accept) begin
            r_out <= w_lookup;
         end
      end
   end

   assign bus_if.tready     = w_sbox_ready;
   assign bus_if.valid      = r_valid;
   assign bus_if.out        = r_out;
   assign bus_if.sbox_ready = w_sbox_ready;
   assign bus_if.sbox_err   = w_sbox_err;

endmodule : inv_subbytes
`default_nettype wire

// File: doc/inv_subbytes.md
Name: inv_subbytes

Overview:
Inverse SubBytes stage for the AES decryption datapath: applies InvSBox to all 16 bytes of a 128-bit state.
- Builds the inverse table from the same serial forward S-box stream (one byte per beat, index 0..255) that feeds the encryption SubBytes stage. Entry i carrying value v writes inv_mem[v] <= i.
- Checks the streamed table is a bijection and locks out lookups if it is not.

Parameters:
SBOX_WIDTH, 8, byte width of S-box entries
SBOX_DEPTH, 256, number of S-box entries streamed
DATA_WIDTH, 128, state width; must be a multiple of 8

Ports:
clk  input  1  clock, rising edge
reset_n  input  1  asynchronous, active-low reset
sbox_valid  input  1  forward S-box beat valid
sbox_out  input  8  forward S-box value S(index), index implicit (0,1,2,...)
tvalid  input  1  lookup request valid
in  input  DATA_WIDTH  ciphertext-side state bytes
tready  output  1  high when a lookup is accepted this cycle (== sbox_ready)
valid  output  1  one-cycle pulse, out is a fresh result
out  output  DATA_WIDTH  InvSBox applied per byte lane
sbox_ready  output  1  inverse table complete and verified
sbox_err  output  1  duplicate value detected in streamed table (sticky)

Behaviour:
- Reset (async, any time including mid-load): state=LOAD, index=0, written bitmap (256b) cleared, inv_mem cleared to 0, valid=0, out=0, sbox_ready=0, sbox_err=0, tready=0.
- FSM states: LOAD, READY, ERROR.
- LOAD, beat accepted when sbox_valid=1:
  - if written[sbox_out]=1 -> ERROR at that edge; no write.
  - else inv_mem[sbox_out]<=index, written[sbox_out]<=1, index<=index+1.
  - If index==SBOX_DEPTH-1 and no duplicate -> READY. sbox_ready rises the cycle after the 256th beat.
  - 256 distinct values guarantees full coverage; no separate completeness check.
- READY: sbox_valid ignored; table frozen until reset.
- ERROR: sbox_err=1, sbox_ready=0, tready=0; all further beats and lookups ignored; exit only by reset.
- Lookup (READY only), tvalid=1 at edge:
  - out[i*8+:8] <= inv_mem[in[i*8+:8]] for i=0..15.
  - valid<=1. Latency 1 cycle; throughput 1 per cycle, back-to-back allowed.
- tvalid=0, or not READY: valid<=0, out holds its last value. tvalid during LOAD/ERROR is dropped silently: no valid pulse, no queueing.
- sbox_valid gaps during LOAD allowed; index advances only on accepted beats.
- Index wrap: impossible. FSM leaves LOAD at 255.

Decomposition:
- Shared package aes_pkg:
  - SBOX_WIDTH/SBOX_DEPTH constants.
  - inv-sbox FSM state enum (LOAD/READY/ERROR).
  - FIPS-197 reference constants used by benches.
- One sub-module: inv_sbox_builder. Contains inv_mem, written bitmap, index counter and FSM. Exports a read function/port array plus sbox_ready/sbox_err.
- The top holds the 16-lane lookup register stage.

Test Plan:
1. Stream full AES S-box (S(00)=63, S(01)=7C, S(53)=ED) with no gaps -> sbox_ready=1 exactly 1 cycle after beat 255; sbox_err=0.
2. After load, in=128'h6363...63 then in=128'hEDED...ED on consecutive cycles -> valid high 2 cycles; out=128'h00...00 then 128'h5353...53.
3. in=128'h637C...(lanes=S(0..15)) -> out=128'h000102...0F lane-matched; round trip of encryption SubBytes output recovers plaintext 128'h00112233445566778899AABBCCDDEEFF.
4. tvalid=1 during LOAD (beat 40) -> no valid pulse, out stays 0; sbox_valid deasserted for 5 cycles mid-load -> ready still after exactly 256 accepted beats.
5. Corrupted stream: beat 5 carries 0x63 (same as beat 0) -> sbox_err=1 the cycle after beat 5, sbox_ready stays 0, later tvalid gives no valid.
6. Assert reset_n low after 100 beats, then stream full table -> ready after 256 new beats; lookup of 0x7C returns 0x01; sbox_err cleared by reset after case 5.
